cam_core: RTL and testbench

Content-addressable memory, the responder behind the CAM bench interface: DEPTH entries of DATA_WIDTH bits with indexed write, indexed read and associative search. Every request is sampled on a rising clock edge and answered with registered outputs one cycle later. The block is the device under test driven by the CAM verification bench through the DUT-side signal set.

---
 rtl/cam_core_if.sv | 35 +++
 rtl/cam_core.sv | 92 +++++++++
 tb/tb_cam_core.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cam_core_if.sv
// CAM request/response bundle: read, write and search requests in, registered results out.
// Latency: none inside the interface; it only groups the signals.
// Backpressure: none; the responder accepts a request of each kind every cycle.
interface cam_core_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5
);
  logic                   read_enable_i;
  logic [INDEX_WIDTH-1:0] read_index_i;
  logic                   write_enable_i;
  logic [INDEX_WIDTH-1:0] write_index_i;
  logic [DATA_WIDTH-1:0]  write_data_i;
  logic                   search_enable_i;
  logic [DATA_WIDTH-1:0]  search_data_i;
  logic                   read_valid_o;
  logic [DATA_WIDTH-1:0]  read_value_o;
  logic                   search_valid_o;
  logic [INDEX_WIDTH-1:0] search_index_o;

  // Requester side (bench / upstream logic)
  modport master (
    output read_enable_i, read_index_i,
    output write_enable_i, write_index_i, write_data_i,
    output search_enable_i, search_data_i,
    input  read_valid_o, read_value_o, search_valid_o, search_index_o
  );

  // Responder side (the CAM itself)
  modport slave (
    input  read_enable_i, read_index_i,
    input  write_enable_i, write_index_i, write_data_i,
    input  search_enable_i, search_data_i,
    output read_valid_o, read_value_o, search_valid_o, search_index_o
  );
endinterface

// File: rtl/cam_core.sv
// CAM with indexed write, indexed read and parallel lowest-index search (macro CAM_WRITE_BYPASS_EN forwards same-cycle writes).
// Latency: read and search results registered, 1 cycle after the request edge; writes visible from the next edge.
// Backpressure: none; one read, one write and one search accepted every cycle.
module cam_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic      clk_i,
  input  logic      rst_i,
  cam_core_if.slave bus
);

  logic [DATA_WIDTH-1:0]  r_data [DEPTH];
  logic [DEPTH-1:0]       r_valid;

  logic                   r_read_valid;
  logic [DATA_WIDTH-1:0]  r_read_value;
  logic                   r_search_valid;
  logic [INDEX_WIDTH-1:0] r_search_index;

  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_rd_valid;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic [DEPTH-1:0]       w_hit;
  logic [INDEX_WIDTH-1:0] w_hit_idx;

  // Indices beyond DEPTH (only possible when DEPTH < 2**INDEX_WIDTH) are ignored
  assign w_wr_ok = bus.write_enable_i && (int'(bus.write_index_i) < DEPTH);
  assign w_rd_ok = int'(bus.read_index_i) < DEPTH;

  // Read lookup; with bypass a same-cycle write to the same entry is forwarded
  always_comb begin
    w_rd_valid = w_rd_ok && r_valid[bus.read_index_i];
    w_rd_data  = r_data[bus.read_index_i];
`ifdef CAM_WRITE_BYPASS_EN
    if (w_rd_ok && w_wr_ok && (bus.read_index_i == bus.write_index_i)) begin
      w_rd_valid = 1'b1;
      w_rd_data  = bus.write_data_i;
    end
`endif
  end

  // Parallel compare of the key against every valid entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = r_valid[i] && (r_data[i] == bus.search_data_i);
`ifdef CAM_WRITE_BYPASS_EN
      // The entry being written is seen with its new contents, old value no longer matches
      if (w_wr_ok && (bus.write_index_i == INDEX_WIDTH'(i)))
        w_hit[i] = (bus.write_data_i == bus.search_data_i);
`endif
    end
  end

  // Priority encoder: lowest matching index wins
  always_comb begin
    w_hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = INDEX_WIDTH'(i);
    end
  end

  // Entry storage; not reset because invalid entries are never observable
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_ok) r_data[bus.write_index_i] <= bus.write_data_i;
  end

  // Valid bits and registered results; reset drops any request in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid        <= '0;
      r_read_valid   <= 1'b0;
      r_read_value   <= '0;
      r_search_valid <= 1'b0;
      r_search_index <= '0;
    end else begin
      if (w_wr_ok) r_valid[bus.write_index_i] <= 1'b1;
      r_read_valid   <= bus.read_enable_i && w_rd_valid;
      r_read_value   <= (bus.read_enable_i && w_rd_valid) ? w_rd_data : '0;
      r_search_valid <= bus.search_enable_i && (|w_hit);
      r_search_index <= (bus.search_enable_i && (|w_hit)) ? w_hit_idx : '0;
    end
  end

  assign bus.read_valid_o   = r_read_valid;
  assign bus.read_value_o   = r_read_value;
  assign bus.search_valid_o = r_search_valid;
  assign bus.search_index_o = r_search_index;

endmodule

// File: tb/tb_cam_core.sv
// Directed bench for cam_core: reset, write/read/search, priority, same-cycle write, reset mid-traffic, streaming.
// Latency: each request is applied for one edge and its result checked 1 time unit after that edge.
// Backpressure: none; the bench issues one request set per cycle.
module tb_cam_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cam_core_if #(.DATA_WIDTH(32), .INDEX_WIDTH(5)) bus ();

  cam_core #(.DATA_WIDTH(32), .DEPTH(32), .INDEX_WIDTH(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic re, input logic [4:0] ri,
                         input logic we, input logic [4:0] wi, input logic [31:0] wd,
                         input logic se, input logic [31:0] sd);
    bus.read_enable_i   = re;
    bus.read_index_i    = ri;
    bus.write_enable_i  = we;
    bus.write_index_i   = wi;
    bus.write_data_i    = wd;
    bus.search_enable_i = se;
    bus.search_data_i   = sd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic rv, input logic [31:0] val,
                           input logic sv, input logic [4:0] si);
    check({tag, ".read_valid"},   32'(bus.read_valid_o),   32'(rv));
    check({tag, ".read_value"},   bus.read_value_o,        val);
    check({tag, ".search_valid"}, 32'(bus.search_valid_o), 32'(sv));
    check({tag, ".search_index"}, 32'(bus.search_index_o), 32'(si));
  endtask

  initial begin
    set_req(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    check_out("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // Empty CAM: read 3 invalid, key 0 must not match invalid entries
    set_req(1, 3, 0, 0, 0, 1, 32'h0000_0000);
    step();
    check_out("empty", 0, 0, 0, 0);

    // Write then read/search on the next cycle
    set_req(0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0);
    step();
    set_req(1, 7, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step();
    check_out("wr7", 1, 32'hDEAD_BEEF, 1, 7);

    // Idle cycle: all outputs drop back to 0
    set_req(0, 7, 0, 0, 0, 0, 32'hDEAD_BEEF);
    step();
    check_out("idle", 0, 0, 0, 0);

    // Lowest-index priority, then overwrite removes the old match
    set_req(0, 0, 1, 20, 32'h1234_5678, 0, 0);
    step();
    set_req(0, 0, 1, 4, 32'h1234_5678, 0, 0);
    step();
    set_req(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    step();
    check_out("prio", 0, 0, 1, 4);
    set_req(0, 0, 1, 4, 32'h0000_0000, 0, 0);
    step();
    set_req(1, 4, 0, 0, 0, 1, 32'h1234_5678);
    step();
    check_out("ovwr", 1, 32'h0000_0000, 1, 20);

    // Same-cycle write + read + search of the same entry
    set_req(0, 0, 1, 9, 32'hA5A5_A5A5, 0, 0);
    step();
    set_req(1, 9, 1, 9, 32'h5A5A_5A5A, 1, 32'h5A5A_5A5A);
    step();
`ifdef CAM_WRITE_BYPASS_EN
    check_out("samecyc", 1, 32'h5A5A_5A5A, 1, 9);
`else
    check_out("samecyc", 1, 32'hA5A5_A5A5, 0, 0);
`endif
    set_req(1, 9, 0, 0, 0, 1, 32'hA5A5_A5A5);
    step();
    check_out("after", 1, 32'h5A5A_5A5A, 0, 0);

    // Fill all entries with 0x100+i
    for (int i = 0; i < 32; i++) begin
      set_req(0, 0, 1, 5'(i), 32'h100 + 32'(i), 0, 0);
      step();
    end
    set_req(1, 31, 0, 0, 0, 1, 32'h11F);
    step();
    check_out("full", 1, 32'h11F, 1, 31);

    // Reset together with a read: request dropped, all outputs 0
    rst = 1'b1;
    set_req(1, 31, 0, 0, 0, 1, 32'h11F);
    step();
    check_out("rstreq", 0, 0, 0, 0);
    rst = 1'b0;
    set_req(1, 31, 0, 0, 0, 1, 32'h11F);
    step();
    check_out("postrst", 0, 0, 0, 0);

    // Refill with 0x300+i, then stream reads every cycle with toggling search
    for (int i = 0; i < 32; i++) begin
      set_req(0, 0, 1, 5'(i), 32'h300 + 32'(i), 0, 0);
      step();
    end
    for (int k = 0; k < 32; k++) begin
      set_req(1, 5'(k), 0, 0, 0, (k % 2) == 1, 32'h300 + 32'(k));
      step();
      if ((k % 2) == 1)
        check_out($sformatf("stream%0d", k), 1, 32'h300 + 32'(k), 1, 5'(k));
      else
        check_out($sformatf("stream%0d", k), 1, 32'h300 + 32'(k), 0, 0);
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    step();
    check_out("tail", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
